// File: rtl/sfp_pkg.sv
// Shared state encoding and sticky-event bit positions for the SFP cage supervisor.
package sfp_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_ABSENT   = 3'd0,
      ST_DISABLED = 3'd1,
      ST_INIT     = 3'd2,
      ST_UP       = 3'd3,
      ST_FRESET   = 3'd4,
      ST_LOCKED   = 3'd5
   } sfp_state_t;

   // event_sticky bit positions within one cage's 3-bit field
   localparam int EV_INS = 0;
   localparam int EV_LOS = 1;
   localparam int EV_FLT = 2;

   // debounced input bit positions within one cage's 3-bit field
   localparam int DB_DET = 0;
   localparam int DB_LOS = 1;
   localparam int DB_FLT = 2;

   // transmitter is only allowed on while initialising or up
   function automatic logic tx_off(input sfp_state_t st);
      return !(st == ST_INIT || st == ST_UP);
   endfunction

endpackage

// File: rtl/sfp_debounce.sv
// Two-flop synchroniser plus per-bit debounce for one cage's {fault, los, detect} pins.
module sfp_debounce #(
   parameter int               WIDTH   = 3,
   parameter int               CYC     = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int CW = $clog2(CYC + 1);

   logic [WIDTH-1:0]         s1, s2;
   logic [WIDTH-1:0][CW-1:0] cnt;

   // sync the async pins, then let each bit follow only after CYC equal samples in a row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         dout <= RST_VAL;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == dout[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(CYC - 1)) begin
               dout[i] <= s2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sfp_port_manager.sv
// Multi-cage SFP supervisor: debounced status, TX_DISABLE FSM with bounded fault recovery.
module sfp_port_manager
   import sfp_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int INIT_CYC     = 30_000_000,
   parameter int FRESET_CYC   = 2_000,
   parameter int MAX_RETRY    = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNELS-1:0]      sfp_detect,
   input  logic [CHANNELS-1:0]      sfp_los,
   input  logic [CHANNELS-1:0]      sfp_fault,
   input  logic [CHANNELS-1:0]      tx_enable,
   input  logic [CHANNELS-1:0]      fault_clear,
   input  logic [CHANNELS-1:0]      event_clear,
   output logic [CHANNELS-1:0]      sfp_disable,
   output logic [CHANNELS-1:0]      led_present,
   output logic [CHANNELS-1:0]      led_link,
   output logic [ST_W*CHANNELS-1:0] state,
   output logic [3*CHANNELS-1:0]    event_sticky,
   output logic [CHANNELS-1:0]      locked
);

   localparam int TMR_MAX = (INIT_CYC > FRESET_CYC) ? INIT_CYC : FRESET_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 1);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [2:0]    db, db_prev_q;
      logic          det, los, flt;
      sfp_state_t    st_q, st_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic [RW-1:0] rty_q, rty_d, rty_inc;
      logic          drop_q, drop_d;
      logic [2:0]    ev_q, ev_d;
      logic          dis_q, pres_q, link_q, lock_q;

      // debounced detect/los reset to "absent, no light", fault to idle
      sfp_debounce #(.WIDTH(3), .CYC(DEBOUNCE_CYC), .RST_VAL(3'b011)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .din   ({sfp_fault[ch], sfp_los[ch], sfp_detect[ch]}),
         .dout  (db)
      );

      assign det     = db[DB_DET];
      assign los     = db[DB_LOS];
      assign flt     = db[DB_FLT];
      assign rty_inc = (rty_q == RW'(MAX_RETRY)) ? rty_q : rty_q + 1'b1;

      // next-state logic; a removed module wins over everything else
      always_comb begin
         st_d   = st_q;
         tmr_d  = tmr_q;
         rty_d  = rty_q;
         drop_d = drop_q;
         if (det) begin
            st_d  = ST_ABSENT;
            rty_d = '0;
            tmr_d = '0;
         end else begin
            case (st_q)
               ST_ABSENT:   st_d = ST_DISABLED;
               ST_DISABLED: if (tx_enable[ch]) begin
                  st_d  = ST_INIT;
                  tmr_d = '0;
               end
               ST_INIT: begin
                  if (!tx_enable[ch]) begin
                     st_d = ST_DISABLED;
                  end else if (tmr_q == TW'(INIT_CYC - 1)) begin
                     if (flt) begin
                        st_d   = ST_FRESET;
                        tmr_d  = '0;
                        rty_d  = rty_inc;
                        drop_d = 1'b0;
                     end else begin
                        st_d  = ST_UP;
                        rty_d = '0;
                     end
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
               ST_UP: begin
                  if (flt) begin
                     st_d   = ST_FRESET;
                     tmr_d  = '0;
                     rty_d  = rty_inc;
                     drop_d = 1'b0;
                  end else if (!tx_enable[ch]) begin
                     st_d = ST_DISABLED;
                  end
               end
               ST_FRESET: begin
                  // a user disable seen at any point is honoured once the pulse completes
                  drop_d = drop_q | ~tx_enable[ch];
                  if (tmr_q == TW'(FRESET_CYC - 1)) begin
                     tmr_d = '0;
                     if (drop_d)                       st_d = ST_DISABLED;
                     else if (rty_q < RW'(MAX_RETRY))  st_d = ST_INIT;
                     else                              st_d = ST_LOCKED;
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
               ST_LOCKED: if (fault_clear[ch]) begin
                  st_d  = ST_DISABLED;
                  rty_d = '0;
               end
               default: st_d = ST_ABSENT;
            endcase
         end
      end

      // sticky events: a new edge beats a same-cycle clear
      always_comb begin
         ev_d = event_clear[ch] ? 3'b000 : ev_q;
         if (det != db_prev_q[DB_DET])                ev_d[EV_INS] = 1'b1;
         if (los && !db_prev_q[DB_LOS] && !det)       ev_d[EV_LOS] = 1'b1;
         if (flt && !db_prev_q[DB_FLT])               ev_d[EV_FLT] = 1'b1;
      end

      // state, timers and registered outputs, all aligned to the state register
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            st_q      <= ST_ABSENT;
            tmr_q     <= '0;
            rty_q     <= '0;
            drop_q    <= 1'b0;
            db_prev_q <= 3'b011;
            ev_q      <= '0;
            dis_q     <= 1'b1;
            pres_q    <= 1'b0;
            link_q    <= 1'b0;
            lock_q    <= 1'b0;
         end else begin
            st_q      <= st_d;
            tmr_q     <= tmr_d;
            rty_q     <= rty_d;
            drop_q    <= drop_d;
            db_prev_q <= db;
            ev_q      <= ev_d;
            dis_q     <= tx_off(st_d);
            pres_q    <= !det;
            link_q    <= (st_d == ST_UP) && !los;
            lock_q    <= (st_d == ST_LOCKED);
         end
      end

      assign sfp_disable[ch]             = dis_q;
      assign led_present[ch]             = pres_q;
      assign led_link[ch]                = link_q;
      assign locked[ch]                  = lock_q;
      assign state[ST_W*ch +: ST_W]      = st_q;
      assign event_sticky[3*ch +: 3]     = ev_q;
   end

endmodule

// File: tb/tb_sfp_port_manager.sv
// Directed bench for sfp_port_manager with short timing parameters.
module tb_sfp_port_manager;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] sfp_detect, sfp_los, sfp_fault, tx_enable, fault_clear, event_clear;
   logic [1:0] sfp_disable, led_present, led_link, locked;
   logic [5:0] state, event_sticky;

   int n_chk  = 0;
   int n_fail = 0;

   sfp_port_manager #(
      .CHANNELS(2), .DEBOUNCE_CYC(4), .INIT_CYC(20), .FRESET_CYC(5), .MAX_RETRY(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sfp_detect   (sfp_detect),
      .sfp_los      (sfp_los),
      .sfp_fault    (sfp_fault),
      .tx_enable    (tx_enable),
      .fault_clear  (fault_clear),
      .event_clear  (event_clear),
      .sfp_disable  (sfp_disable),
      .led_present  (led_present),
      .led_link     (led_link),
      .state        (state),
      .event_sticky (event_sticky),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   // advance n rising edges, land 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Edge numbering in comments: inputs change just after edge 0 of each step.
   // Debounced value flips at edge 6 (2 sync + 4 samples); FSM reacts at edge 7.
   initial begin
      rst_n = 1'b0; sfp_detect = 2'b11; sfp_los = 2'b11; sfp_fault = 2'b00;
      tx_enable = 2'b00; fault_clear = 2'b00; event_clear = 2'b00;

      // 1: reset state
      tick(3);
      chk("rst_disable", 32'(sfp_disable), 32'h3);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_led_present", 32'(led_present), 32'h0);
      chk("rst_led_link", 32'(led_link), 32'h0);
      chk("rst_sticky", 32'(event_sticky), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // 2: ch0 inserted and enabled, comes up
      sfp_detect[0] = 1'b0; sfp_los[0] = 1'b0; tx_enable = 2'b01;
      tick(6);  chk("t2_e6_absent", 32'(state[2:0]), 32'd0);
      tick(1);  chk("t2_e7_disabled", 32'(state[2:0]), 32'd1);
                chk("t2_e7_present", 32'(led_present), 32'h1);
                chk("t2_e7_insert_ev", 32'(event_sticky), 32'h01);
      tick(1);  chk("t2_e8_init", 32'(state[2:0]), 32'd2);
                chk("t2_e8_disable", 32'(sfp_disable), 32'h2);
      tick(19); chk("t2_e27_init", 32'(state[2:0]), 32'd2);
      tick(1);  chk("t2_e28_up", 32'(state[2:0]), 32'd3);
                chk("t2_e28_link", 32'(led_link), 32'h1);
                chk("t2_ch1_absent", 32'(state[5:3]), 32'd0);
                chk("t2_ch1_disable", 32'(sfp_disable[1]), 32'h1);

      // 3: steady fault -> two resets -> LOCKED; fault_clear recovers
      sfp_fault[0] = 1'b1;
      tick(6);  chk("t3_e6_up", 32'(state[2:0]), 32'd3);
                chk("t3_e6_dis", 32'(sfp_disable[0]), 32'h0);
      tick(1);  chk("t3_e7_freset", 32'(state[2:0]), 32'd4);
                chk("t3_e7_dis", 32'(sfp_disable[0]), 32'h1);
      tick(4);  chk("t3_e11_dis", 32'(sfp_disable[0]), 32'h1);
      tick(1);  chk("t3_e12_init", 32'(state[2:0]), 32'd2);
                chk("t3_e12_dis", 32'(sfp_disable[0]), 32'h0);
      tick(20); chk("t3_e32_freset2", 32'(state[2:0]), 32'd4);
      tick(5);  chk("t3_e37_locked", 32'(state[2:0]), 32'd5);
                chk("t3_locked", 32'(locked), 32'h1);
                chk("t3_locked_dis", 32'(sfp_disable[0]), 32'h1);
                chk("t3_fault_ev", 32'(event_sticky[2:0]), 32'h5);
      sfp_fault[0] = 1'b0; tx_enable[0] = 1'b0;
      tick(8);
      tx_enable[0] = 1'b1;
      tick(2);  chk("t3_lock_holds", 32'(state[2:0]), 32'd5);
      fault_clear = 2'b01;
      tick(1);  fault_clear = 2'b00;
                chk("t3_fclr_disabled", 32'(state[2:0]), 32'd1);
                chk("t3_fclr_unlock", 32'(locked), 32'h0);
      tick(1);  chk("t3_reinit", 32'(state[2:0]), 32'd2);
      tick(20); chk("t3_up_again", 32'(state[2:0]), 32'd3);

      // 4: 3-cycle detect glitch is filtered
      sfp_detect[0] = 1'b1;
      tick(3);  sfp_detect[0] = 1'b0;
      tick(10); chk("t4_glitch_state", 32'(state[2:0]), 32'd3);
                chk("t4_glitch_ev", 32'(event_sticky[2:0]), 32'h5);

      // 4: ch1 removed in the middle of INIT
      sfp_detect[1] = 1'b0; tx_enable[1] = 1'b1;
      tick(7);  chk("t4_ch1_disabled", 32'(state[5:3]), 32'd1);
                chk("t4_ch1_ins_ev", 32'(event_sticky[5:3]), 32'h1);
      tick(1);  chk("t4_ch1_init", 32'(state[5:3]), 32'd2);
      event_clear = 2'b10;
      tick(1);  event_clear = 2'b00;
                chk("t4_ch1_evclr", 32'(event_sticky[5:3]), 32'h0);
      tick(4);  sfp_detect[1] = 1'b1;                      // edge 13
      tick(6);  chk("t4_e19_init", 32'(state[5:3]), 32'd2);
                chk("t4_e19_dis", 32'(sfp_disable[1]), 32'h0);
      tick(1);  chk("t4_e20_absent", 32'(state[5:3]), 32'd0);
                chk("t4_e20_dis", 32'(sfp_disable[1]), 32'h1);
                chk("t4_remove_ev", 32'(event_sticky[5:3]), 32'h1);
                chk("t4_ch0_up", 32'(state[2:0]), 32'd3);

      // 5: LOS rise coinciding with clear leaves los_rise set
      event_clear = 2'b01;
      tick(1);  event_clear = 2'b00;
                chk("t5_clear", 32'(event_sticky[2:0]), 32'h0);
      sfp_los[0] = 1'b1;
      tick(6);  event_clear = 2'b01;
      tick(1);  event_clear = 2'b00;
                chk("t5_set_wins", 32'(event_sticky[2:0]), 32'h2);
                chk("t5_link_drop", 32'(led_link[0]), 32'h0);
      event_clear = 2'b01;
      tick(1);  event_clear = 2'b00;
                chk("t5_clear_alone", 32'(event_sticky[2:0]), 32'h0);

      // 6: reset asserted in the middle of FRESET
      sfp_fault[0] = 1'b1;
      tick(7);  chk("t6_freset", 32'(state[2:0]), 32'd4);
      tick(1);
      rst_n = 1'b0;
      tick(1);  chk("t6_disable", 32'(sfp_disable), 32'h3);
                chk("t6_state", 32'(state), 32'h0);
                chk("t6_led_present", 32'(led_present), 32'h0);
                chk("t6_led_link", 32'(led_link), 32'h0);
                chk("t6_locked", 32'(locked), 32'h0);
                chk("t6_sticky", 32'(event_sticky), 32'h0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
